// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM encoding and default sizes.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_AW    = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear.
module alu_regfile #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] rf_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= '0;
      end
    end else if (we) begin
      rf_q[waddr] <= wdata;
    end
  end

  assign rdata_a = rf_q[raddr_a];
  assign rdata_b = rf_q[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the external combinational ALU: reads operands from the register file,
// drives the ALU for one cycle, then writes the result back and pulses done.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = DEFAULT_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       instr_op,
  input  logic [AW-1:0]    instr_rd,
  input  logic [AW-1:0]    instr_rs1,
  input  logic [AW-1:0]    instr_rs2,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_i0,
  output logic [WIDTH-1:0] alu_i1,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_cout,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  state_e           state_q, state_d;
  logic [AW-1:0]    rd_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] i0_q, i1_q, result_q;
  logic             carry_q, done_q;

  logic             handshake;
  logic [WIDTH-1:0] rs1_data, rs2_data;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  // A pending load blocks issue so the load and an instruction never share a cycle.
  assign instr_ready = rst_n && (state_q == IDLE) && !ld_en;
  assign handshake   = instr_valid && instr_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (handshake) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writeback owns the port in EXEC; loads are only honoured in IDLE.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (state_q == EXEC) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = alu_o;
    end else if (ld_en) begin
      rf_we = 1'b1;
    end
  end

  alu_regfile #(
    .WIDTH(WIDTH),
    .NREGS(NREGS),
    .AW   (AW)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr_a(instr_rs1),
    .rdata_a(rs1_data),
    .raddr_b(instr_rs2),
    .rdata_b(rs2_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      op_q     <= '0;
      i0_q     <= '0;
      i1_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == EXEC);
      if (handshake) begin
        op_q <= instr_op;
        rd_q <= instr_rd;
        i0_q <= rs1_data;
        i1_q <= rs2_data;
      end
      if (state_q == EXEC) begin
        result_q <= alu_o;
        carry_q  <= alu_cout;
      end
    end
  end

  assign alu_op = op_q;
  assign alu_i0 = i0_q;
  assign alu_i1 = i1_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomised scoreboard bench for alu_issue_ctrl with a behavioural ALU beside it.
module tb_alu_issue_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned NR = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [1:0]    instr_op = '0;
  logic [AW-1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [W-1:0]  ld_data = '0;
  logic [1:0]    alu_op;
  logic [W-1:0]  alu_i0, alu_i1, alu_o, result;
  logic          alu_cout, done, carry;

  always #5 clk = ~clk;

  // ALU stand-in: cout flags unsigned carry/borrow or signed overflow for ADD/SUB, 0 for logic ops.
  function automatic logic [W:0] alu_fn(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] d;
    logic         ovf;
    case (op)
      2'b00: begin
        s   = {1'b0, a} + {1'b0, b};
        ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {s[W] | ovf, s[W-1:0]};
      end
      2'b01: begin
        d   = a - b;
        ovf = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        return {(a < b) | ovf, d};
      end
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  logic [W:0] alu_res;
  assign alu_res  = alu_fn(alu_op, alu_i0, alu_i1);
  assign alu_o    = alu_res[W-1:0];
  assign alu_cout = alu_res[W];

  alu_issue_ctrl #(.WIDTH(W), .NREGS(NR), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op   (instr_op),
    .instr_rd   (instr_rd),
    .instr_rs1  (instr_rs1),
    .instr_rs2  (instr_rs2),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .alu_op     (alu_op),
    .alu_i0     (alu_i0),
    .alu_i1     (alu_i1),
    .alu_o      (alu_o),
    .alu_cout   (alu_cout),
    .done       (done),
    .result     (result),
    .carry      (carry)
  );

  typedef struct {
    logic [W-1:0]  res;
    logic          c;
    logic [AW-1:0] rd;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] ref_rf [NR];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_regs(input string name);
    for (int i = 0; i < int'(NR); i++) begin
      check(name, {16'h0, dut.u_rf.rf_q[i]}, {16'h0, ref_rf[i]});
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding instruction.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", {16'h0, result}, {16'h0, e.res});
        check("carry", {31'h0, carry}, {31'h0, e.c});
        check("rf_writeback", {16'h0, dut.u_rf.rf_q[e.rd]}, {16'h0, e.res});
      end
    end
  end

  task automatic do_load(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    ref_rf[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Issues one instruction; nloads stall cycles with ld_en held first; optional ld_en in EXEC.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input int nloads, input bit ld_in_exec);
    int   waited;
    exp_t e;
    logic [W:0] r;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    for (int k = 0; k < nloads; k++) begin
      ld_en = 1'b1; ld_addr = AW'($urandom); ld_data = W'($urandom);
      #1 check("stall_ready", {31'h0, instr_ready}, 32'd0);
      @(posedge clk);
      ref_rf[ld_addr] = ld_data;
      @(negedge clk);
    end
    ld_en = 1'b0;
    #1;
    waited = 0;
    while (!instr_ready && waited < 20) begin
      @(posedge clk); @(negedge clk); #1;
      waited++;
    end
    check("issue_ready", {31'h0, instr_ready}, 32'd1);
    if (instr_ready) begin
      r     = alu_fn(op, ref_rf[rs1], ref_rf[rs2]);
      e.res = r[W-1:0];
      e.c   = r[W];
      e.rd  = rd;
      exp_q.push_back(e);
      ref_rf[rd] = e.res;
      @(posedge clk);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    if (ld_in_exec) begin
      ld_en = 1'b1; ld_addr = AW'($urandom); ld_data = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      ld_en = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < int'(NR); i++) ref_rf[i] = '0;

    // Reset state
    #12;
    check("rst_ready", {31'h0, instr_ready}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_result", {16'h0, result}, 32'd0);
    check("rst_carry", {31'h0, carry}, 32'd0);
    check("rst_alu_in", {14'h0, alu_op, alu_i0}, 32'd0);
    check("rst_alu_i1", {16'h0, alu_i1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_rst", {31'h0, instr_ready}, 32'd1);

    // Signed-overflow ADD
    do_load(3'd1, 16'h7FFF);
    do_load(3'd2, 16'h0001);
    issue(2'b00, 3'd3, 3'd1, 3'd2, 0, 1'b0);

    // SUB with borrow, then dependent AND reusing rd as source
    do_load(3'd4, 16'h0005);
    do_load(3'd5, 16'h0007);
    issue(2'b01, 3'd6, 3'd4, 3'd5, 0, 1'b0);
    issue(2'b10, 3'd6, 3'd6, 3'd4, 0, 1'b0);

    // Load wins over a simultaneous instruction for two cycles
    issue(2'b00, 3'd7, 3'd3, 3'd6, 2, 1'b0);

    // OR into a source register, load attempted during EXEC is dropped
    do_load(3'd1, 16'h00F0);
    do_load(3'd2, 16'h0F00);
    issue(2'b11, 3'd1, 3'd1, 3'd2, 0, 1'b1);
    repeat (2) @(negedge clk);
    check_all_regs("regs_after_or");

    // Randomised mix
    for (int n = 0; n < 40; n++) begin
      int nl;
      nl = int'($urandom_range(0, 2));
      for (int k = 0; k < nl; k++) do_load(AW'($urandom), W'($urandom));
      issue(2'($urandom_range(0, 3)), AW'($urandom), AW'($urandom), AW'($urandom),
            int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    check_all_regs("regs_after_random");

    // Reset during EXEC aborts the writeback
    do_load(3'd1, 16'hFFFF);
    do_load(3'd2, 16'h0001);
    issue(2'b00, 3'd3, 3'd1, 3'd2, 0, 1'b0);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < int'(NR); i++) ref_rf[i] = '0;
    #1;
    check("abort_ready", {31'h0, instr_ready}, 32'd0);
    check("abort_done", {31'h0, done}, 32'd0);
    check("abort_result", {16'h0, result}, 32'd0);
    check("abort_carry", {31'h0, carry}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("abort_ready_release", {31'h0, instr_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check_all_regs("regs_after_abort");
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
